// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: instruction-fetch stage with a DEPTH-entry prefetch queue
// between the Wishbone classic instruction port and IF/ID (valid/ready).
// Optional build macro: IF_PREFETCH_BYPASS_EN. When it is defined, an ack that
// arrives while the queue is empty is presented to IF/ID in the same cycle.
module if_prefetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [31:0]              br_j_addr_i,
    input  logic [31:0]              exception_addr_i,
    input  logic [1:0]               sel_addr_i,
    input  logic                     instr_ready_i,
    output logic                     instr_valid_o,
    output logic [31:0]              instruction_o,
    output logic [31:0]              pc_o,
    output logic                     e_inst_access_fault_o,
    output logic [$clog2(DEPTH):0]   occupancy_o,
    input  logic [31:0]              wbm_dat_i,
    input  logic                     wbm_ack_i,
    input  logic                     wbm_err_i,
    output logic                     wbm_cyc_o,
    output logic                     wbm_stb_o,
    output logic [31:0]              wbm_addr_o
);

    localparam int unsigned   AW   = $clog2(DEPTH);
    localparam int unsigned   CW   = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [31:0]   NOP  = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DISCARD, S_HALT} state_t;

    state_t         r_state, w_state_n;
    logic [31:0]    r_fetch_pc;
    logic [31:0]    r_addr;
    logic [AW-1:0]  r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]  r_count;
    logic [31:0]    r_pc_mem  [DEPTH];
    logic [31:0]    r_ins_mem [DEPTH];
    logic [DEPTH-1:0] r_flt_mem;

    logic           w_redirect;
    logic [31:0]    w_target;
    logic           w_resp;
    logic           w_in_bus;
    logic           w_q_valid;
    logic           w_pop;
    logic           w_bypass;
    logic           w_push;
    logic [CW-1:0]  w_count_n;
    logic           w_issue;
    logic [31:0]    w_issue_pc;

    assign w_redirect = |sel_addr_i;
    assign w_target   = sel_addr_i[1] ? exception_addr_i : br_j_addr_i;
    assign w_resp     = wbm_ack_i | wbm_err_i;
    assign w_in_bus   = (r_state == S_BUS);
    assign w_q_valid  = (r_count != '0);
    assign w_pop      = w_q_valid && instr_ready_i;

`ifdef IF_PREFETCH_BYPASS_EN
    assign w_bypass = w_in_bus && wbm_ack_i && !wbm_err_i && !w_redirect && !w_q_valid;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed beat that IF/ID accepts immediately never occupies a slot.
    assign w_push    = w_in_bus && w_resp && !w_redirect && !(w_bypass && instr_ready_i);
    assign w_count_n = r_count + CW'(w_push) - CW'(w_pop);

    assign wbm_cyc_o   = (r_state == S_BUS) || (r_state == S_DISCARD);
    assign wbm_stb_o   = wbm_cyc_o;
    assign wbm_addr_o  = r_addr;
    assign occupancy_o = r_count;

    // Fetch FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_n;
    end

    // Next state and request issue; a request is only issued when a slot is free for it.
    always_comb begin
        w_state_n  = r_state;
        w_issue    = 1'b0;
        w_issue_pc = r_fetch_pc;
        case (r_state)
            S_IDLE: begin
                if (w_redirect) begin
                    w_state_n  = S_BUS;
                    w_issue    = 1'b1;
                    w_issue_pc = w_target;
                end else if (r_count < FULL) begin
                    w_state_n = S_BUS;
                    w_issue   = 1'b1;
                end
            end
            S_BUS: begin
                if (w_redirect) begin
                    w_state_n = w_resp ? S_IDLE : S_DISCARD;
                end else if (wbm_err_i) begin
                    w_state_n = S_HALT;
                end else if (wbm_ack_i) begin
                    if (w_count_n < FULL) begin
                        w_issue    = 1'b1;
                        w_issue_pc = r_fetch_pc + 32'd4;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
            end
            S_DISCARD: begin
                if (w_resp) w_state_n = S_IDLE;
            end
            S_HALT: begin
                if (w_redirect) begin
                    w_state_n  = S_BUS;
                    w_issue    = 1'b1;
                    w_issue_pc = w_target;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Fetch pc tracks the outstanding request; the bus address is latched at issue so it
    // stays stable through DISCARD even though fetch_pc already points at the new target.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fetch_pc <= RESET_ADDR;
            r_addr     <= '0;
        end else begin
            if (w_redirect)
                r_fetch_pc <= w_target;
            else if (w_in_bus && wbm_ack_i && !wbm_err_i)
                r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_issue)
                r_addr <= w_issue_pc & 32'hFFFF_FFFC;
        end
    end

    // Queue pointers and occupancy; a redirect flush overrides any push or pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_redirect) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_n;
        end
    end

    // Queue storage; bus errors are stored as a NOP tagged with the fault bit.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]  <= r_fetch_pc;
            r_ins_mem[r_wr_ptr] <= wbm_err_i ? NOP : wbm_dat_i;
            r_flt_mem[r_wr_ptr] <= wbm_err_i;
        end
    end

    // Head-of-queue outputs, forced to zero while empty; optional same-cycle bypass.
    always_comb begin
        instr_valid_o         = w_q_valid;
        instruction_o         = w_q_valid ? r_ins_mem[r_rd_ptr] : '0;
        pc_o                  = w_q_valid ? r_pc_mem[r_rd_ptr]  : '0;
        e_inst_access_fault_o = w_q_valid && r_flt_mem[r_rd_ptr];
        if (w_bypass) begin
            instr_valid_o         = 1'b1;
            instruction_o         = wbm_dat_i;
            pc_o                  = r_fetch_pc;
            e_inst_access_fault_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit (DEPTH=4) with a scoreboard of expected
// pc/instruction/fault entries checked whenever IF/ID accepts an entry.
module tb_if_prefetch_unit;

`ifdef IF_PREFETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] br, exc, dat;
    logic [1:0]  sel;
    logic        ready, ack, err;
    logic        valid, fault, cyc, stb;
    logic [31:0] ins, pc, addr;
    logic [2:0]  occ;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        flt;
    } ent_t;

    ent_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    if_prefetch_unit #(.RESET_ADDR(32'h8000_0000), .DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .br_j_addr_i(br), .exception_addr_i(exc), .sel_addr_i(sel),
        .instr_ready_i(ready), .instr_valid_o(valid), .instruction_o(ins),
        .pc_o(pc), .e_inst_access_fault_o(fault), .occupancy_o(occ),
        .wbm_dat_i(dat), .wbm_ack_i(ack), .wbm_err_i(err),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_addr_o(addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; compare any accepted head entry against the scoreboard.
    task automatic step();
        ent_t e;
        #1;
        if (valid && ready) begin
            if (sb.size() > 0) e = sb.pop_front();
            else               e = 'x;
            chk("pop_pc", pc, e.pc);
            chk("pop_ins", ins, e.ins);
            chk("pop_flt", {31'b0, fault}, {31'b0, e.flt});
        end
        @(negedge clk);
    endtask

    // Wait (bounded) for a request, check its address, answer with ack or err.
    task automatic bus_beat(input logic [31:0] p, input logic [31:0] d, input logic e, input bit push);
        ent_t n;
        int   k = 0;
        while (!(cyc && stb) && k < 20) begin
            step();
            k++;
        end
        chk("req_seen", {31'b0, cyc && stb}, 32'd1);
        chk("req_addr", addr, p & 32'hFFFF_FFFC);
        ack = !e;
        err = e;
        dat = d;
        if (push) begin
            n.pc  = p;
            n.ins = e ? 32'h0000_0013 : d;
            n.flt = e;
            sb.push_back(n);
        end
        step();
        ack = 1'b0;
        err = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() > 0 && k < 20) begin
            step();
            k++;
        end
        chk("drain_left", sb.size(), 0);
        chk("drain_occ", {29'b0, occ}, 32'd0);
    endtask

    // Redirect while a request is outstanding; the old address must be held until the
    // late ack, whose data must be dropped.
    task automatic redirect_discard(input logic [31:0] target, input logic [31:0] held);
        chk("redir_pre_cyc", {31'b0, cyc}, 32'd1);
        sel = 2'b01;
        br  = target;
        step();
        sel = 2'b00;
        chk("discard_cyc", {31'b0, cyc}, 32'd1);
        chk("discard_addr", addr, held);
        step();
        step();
        ack = 1'b1;
        dat = 32'hDEAD_BEEF;
        step();
        ack = 1'b0;
        chk("discard_occ", {29'b0, occ}, 32'd0);
        chk("discard_valid", {31'b0, valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; br = '0; exc = '0; sel = '0; ready = 1'b0;
        ack = 1'b0; err = 1'b0; dat = '0;
        repeat (2) @(negedge clk);
        chk("rst_cyc",   {31'b0, cyc},   32'd0);
        chk("rst_stb",   {31'b0, stb},   32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_occ",   {29'b0, occ},   32'd0);
        chk("rst_addr",  addr,           32'd0);
        chk("rst_ins",   ins,            32'd0);
        chk("rst_pc",    pc,             32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        rst = 1'b0;
        step();

        // First request one cycle after reset release; entry visible one cycle after ack.
        chk("first_cyc", {31'b0, cyc}, 32'd1);
        bus_beat(32'h8000_0000, 32'h1111_1111, 1'b0, 1'b1);
        chk("lat_valid", {31'b0, valid}, 32'd1);
        chk("lat_pc",    pc,  32'h8000_0000);
        chk("lat_ins",   ins, 32'h1111_1111);
        chk("lat_occ",   {29'b0, occ}, 32'd1);

        // Fill with IF/ID stalled: exactly DEPTH entries, then no further requests.
        for (int unsigned i = 1; i < 4; i++)
            bus_beat(32'h8000_0000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0, 1'b1);
        chk("full_occ", {29'b0, occ}, 32'd4);
        for (int i = 0; i < 3; i++) begin
            chk("full_nocyc", {31'b0, cyc}, 32'd0);
            step();
        end
        ready = 1'b1;
        drain();

        // Redirect during BUS with a late ack.
        redirect_discard(32'h8000_0100, 32'h8000_0010);
        bus_beat(32'h8000_0100, 32'h2222_2222, 1'b0, 1'b1);
        drain();

        // Exception wins over branch; redirect coinciding with ack drops the data.
        chk("excw_cyc", {31'b0, cyc}, 32'd1);
        sel = 2'b11; exc = 32'h8000_0400; br = 32'h8000_0100;
        ack = 1'b1;  dat = 32'hBAD0_BAD0;
        step();
        sel = 2'b00; ack = 1'b0;
        chk("excw_occ",   {29'b0, occ},   32'd0);
        chk("excw_valid", {31'b0, valid}, 32'd0);
        bus_beat(32'h8000_0400, 32'h4040_4040, 1'b0, 1'b1);
        drain();

        // Bus error becomes a fault NOP entry; fetch halts until redirected.
        redirect_discard(32'h8000_0000, 32'h8000_0404);
        bus_beat(32'h8000_0000, 32'h5555_0000, 1'b0, 1'b1);
        bus_beat(32'h8000_0004, 32'h5555_0004, 1'b0, 1'b1);
        bus_beat(32'h8000_0008, 32'h5555_0008, 1'b1, 1'b1);
        drain();
        for (int i = 0; i < 4; i++) begin
            chk("halt_nocyc", {31'b0, cyc}, 32'd0);
            step();
        end
        sel = 2'b01; br = 32'hFFFF_FFFC;
        step();
        sel = 2'b00;
        bus_beat(32'hFFFF_FFFC, 32'h3333_3333, 1'b0, 1'b1);
        bus_beat(32'h0000_0000, 32'h4444_4444, 1'b0, 1'b1);
        drain();

        // Misaligned target: fetched word-aligned, pc keeps the low bits.
        redirect_discard(32'h8000_0202, 32'h0000_0004);
        bus_beat(32'h8000_0202, 32'h6666_6666, 1'b0, 1'b1);
        bus_beat(32'h8000_0206, 32'h7777_7777, 1'b0, 1'b1);
        drain();

        // Empty queue, IF/ID ready: same-cycle visibility only with the bypass built in.
        begin
            ent_t n;
            chk("byp_cyc",  {31'b0, cyc}, 32'd1);
            chk("byp_addr", addr, 32'h8000_0208);
            n.pc = 32'h8000_020A; n.ins = 32'h9999_9999; n.flt = 1'b0;
            ack = 1'b1; dat = 32'h9999_9999;
            sb.push_back(n);
            #1;
            chk("byp_valid_ack", {31'b0, valid}, {31'b0, BYP});
            chk("byp_occ_ack",   {29'b0, occ},   32'd0);
            step();
            ack = 1'b0;
            chk("byp_occ_after", {29'b0, occ}, BYP ? 32'd0 : 32'd1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
